otbn_keccak_plane_seq: RTL and testbench

Plane-serial sequencer for the Keccak theta and chi steps. It owns a 1600-bit state of 5 planes x 5 lanes x 64 bits and time-multiplexes one combinational plane unit over the planes. It issues plane-unit operations, captures results and writes them back. It sits between the OTBN PQ instruction decode/WDR path (start, load, readout) and the plane unit.

---
 rtl/otbn_keccak_plane_seq.sv | 182 ++++++++++++++++++
 tb/tb_otbn_keccak_plane_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/otbn_keccak_plane_seq.sv
// Plane-serial Keccak theta/chi sequencer driving one external combinational plane unit.
// Optional: define OTBN_KECCAK_PLANE_SEQ_IOTA_EN to add rc_i and fold iota into chi lane (0,0).
module otbn_keccak_plane_seq #(
  parameter int PQLEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             plane_we_i,
  input  logic [2:0]       plane_idx_i,
  input  logic [319:0]     plane_wdata_i,
  output logic [319:0]     plane_rdata_o,
  output logic             pu_op_o,
  output logic [PQLEN*8-1:0] pu_operand_a_o,
  output logic [PQLEN*8-1:0] pu_operand_b_o,
  input  logic [PQLEN*8-1:0] pu_rs0_i,
`ifdef OTBN_KECCAK_PLANE_SEQ_IOTA_EN
  input  logic [63:0]      rc_i,
`endif
  input  logic [PQLEN*8-1:0] pu_rs1_i
);

  localparam int W = PQLEN * 8;

  typedef enum logic [2:0] {
    IDLE,
    TH_C,
    TH_D,
    TH_APPLY,
    CHI,
    DONE
  } state_t;

  state_t       state;
  logic [2:0]   p;
  logic [319:0] planes [5];
  logic [319:0] c_q;
  logic [319:0] d_q;
  logic         busy_q;
  logic         done_q;
  logic         err_q;
`ifdef OTBN_KECCAK_PLANE_SEQ_IOTA_EN
  logic [63:0]  rc_q;
`endif

  logic [319:0] plane_cur;
  logic [319:0] rdata;
  logic [319:0] pu_src;
  logic [319:0] pu_res;
  logic [319:0] chi_wb;
  logic         unused_rs1;

  assign unused_rs1 = ^pu_rs1_i[W-1:64];

  // Loop-based selection keeps out-of-range indices (5..7) reading as zero.
  always_comb begin
    plane_cur = '0;
    rdata     = '0;
    for (int unsigned y = 0; y < 5; y++) begin
      if (p == 3'(y)) plane_cur = planes[y];
      if (plane_idx_i == 3'(y)) rdata = planes[y];
    end
  end

  assign plane_rdata_o = rdata;

  always_comb begin
    pu_src         = '0;
    pu_op_o        = 1'b0;
    pu_operand_a_o = '0;
    pu_operand_b_o = '0;
    if (state == TH_D) begin
      pu_src = c_q;
    end else if (state == CHI) begin
      pu_src  = plane_cur;
      pu_op_o = 1'b1;
    end
    if (state == TH_D || state == CHI) begin
      pu_operand_a_o = W'(pu_src[255:0]);
      pu_operand_b_o = W'(pu_src[319:256]);
    end
  end

  assign pu_res = {pu_rs1_i[63:0], pu_rs0_i[255:0]};

  always_comb begin
    chi_wb = pu_res;
`ifdef OTBN_KECCAK_PLANE_SEQ_IOTA_EN
    if (p == '0) chi_wb[63:0] = pu_res[63:0] ^ rc_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      p      <= '0;
      c_q    <= '0;
      d_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef OTBN_KECCAK_PLANE_SEQ_IOTA_EN
      rc_q   <= '0;
`endif
      for (int unsigned y = 0; y < 5; y++) planes[y] <= '0;
    end else begin
      err_q  <= plane_we_i && (state != IDLE || plane_idx_i > 3'd4);
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          for (int unsigned y = 0; y < 5; y++) begin
            if (plane_we_i && plane_idx_i == 3'(y)) planes[y] <= plane_wdata_i;
          end
          if (start_i) begin
            c_q    <= '0;
            p      <= '0;
            busy_q <= 1'b1;
            state  <= op_i ? CHI : TH_C;
`ifdef OTBN_KECCAK_PLANE_SEQ_IOTA_EN
            rc_q   <= rc_i;
`endif
          end
        end
        TH_C: begin
          c_q <= c_q ^ plane_cur;
          if (p == 3'd4) begin
            p     <= '0;
            state <= TH_D;
          end else begin
            p <= p + 3'd1;
          end
        end
        TH_D: begin
          d_q   <= pu_res;
          p     <= '0;
          state <= TH_APPLY;
        end
        TH_APPLY: begin
          for (int unsigned y = 0; y < 5; y++) begin
            if (p == 3'(y)) planes[y] <= plane_cur ^ d_q;
          end
          if (p == 3'd4) begin
            p      <= '0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            p <= p + 3'd1;
          end
        end
        CHI: begin
          for (int unsigned y = 0; y < 5; y++) begin
            if (p == 3'(y)) planes[y] <= chi_wb;
          end
          if (p == 3'd4) begin
            p      <= '0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            p <= p + 3'd1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_otbn_keccak_plane_seq.sv
// Directed bench for otbn_keccak_plane_seq with a behavioural Keccak plane-unit model.
module tb_otbn_keccak_plane_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         busy, done, err;
  logic         plane_we = 1'b0;
  logic [2:0]   plane_idx = '0;
  logic [319:0] plane_wdata = '0;
  logic [319:0] plane_rdata;
  logic         pu_op;
  logic [255:0] pu_a, pu_b, pu_rs0, pu_rs1;
  logic [63:0]  rc = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  otbn_keccak_plane_seq #(.PQLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .busy_o(busy), .done_o(done), .err_o(err),
    .plane_we_i(plane_we), .plane_idx_i(plane_idx),
    .plane_wdata_i(plane_wdata), .plane_rdata_o(plane_rdata),
    .pu_op_o(pu_op), .pu_operand_a_o(pu_a), .pu_operand_b_o(pu_b),
    .pu_rs0_i(pu_rs0),
`ifdef OTBN_KECCAK_PLANE_SEQ_IOTA_EN
    .rc_i(rc),
`endif
    .pu_rs1_i(pu_rs1)
  );

  // Plane unit: op 0 gives theta D[x] = C[x-1] ^ rotl(C[x+1],1); op 1 gives chi.
  always_comb begin
    logic [63:0] a [5];
    logic [63:0] r [5];
    for (int x = 0; x < 4; x++) a[x] = pu_a[64*x +: 64];
    a[4] = pu_b[63:0];
    for (int x = 0; x < 5; x++) begin
      if (pu_op) r[x] = a[x] ^ (~a[(x+1)%5] & a[(x+2)%5]);
      else       r[x] = a[(x+4)%5] ^ {a[(x+1)%5][62:0], a[(x+1)%5][63]};
    end
    pu_rs0 = {r[3], r[2], r[1], r[0]};
    pu_rs1 = {192'h0, r[4]};
  end

  typedef struct {
    logic          op;
    logic [63:0]   rc;
    logic [1599:0] init;
    logic [1599:0] exp;
  } vec_t;

  vec_t vt [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_state(input logic [1599:0] s);
    for (int y = 0; y < 5; y++) begin
      plane_we    = 1'b1;
      plane_idx   = 3'(y);
      plane_wdata = s[320*y +: 320];
      tick();
    end
    plane_we = 1'b0;
  endtask

  task automatic check_state(input string nm, input logic [1599:0] s);
    for (int y = 0; y < 5; y++) begin
      plane_idx = 3'(y);
      #1;
      chk($sformatf("%s_plane%0d", nm, y), plane_rdata, s[320*y +: 320]);
    end
  endtask

  // Returns the cycle index (1 = first cycle after acceptance) at which done is seen, -1 on timeout.
  task automatic wait_done(output int lat);
    int k;
    k = 1;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    lat = done ? k : -1;
  endtask

  task automatic run_step(input logic o, input logic [63:0] r, output int lat);
    start = 1'b1;
    op    = o;
    rc    = r;
    tick();
    start = 1'b0;
    wait_done(lat);
    tick();
  endtask

  initial begin
    int lat;
    int dcnt;
    int ecnt;
    logic [1599:0] s;

    // Table: lane (x,y) lives at [64*(5y+x) +: 64].
    for (int i = 0; i < 6; i++) begin
      vt[i].rc = '0; vt[i].init = '0; vt[i].exp = '0;
    end
    vt[0].op = 1'b0;
    vt[1].op = 1'b0;
    vt[1].init[0 +: 64] = 64'd1;
    vt[1].exp[0 +: 64]  = 64'd1;
    for (int y = 0; y < 5; y++) begin
      vt[1].exp[64*(5*y+1) +: 64] = 64'd1;
      vt[1].exp[64*(5*y+4) +: 64] = 64'd2;
    end
    vt[2].op = 1'b1;
    vt[2].init[64*2 +: 64] = 64'd1;
    vt[2].exp[64*0 +: 64]  = 64'd1;
    vt[2].exp[64*2 +: 64]  = 64'd1;
`ifdef OTBN_KECCAK_PLANE_SEQ_IOTA_EN
    vt[2].rc = 64'h8000000000000001;
    vt[2].exp[64*0 +: 64] = 64'h8000000000000000;
`endif
    vt[3].op = 1'b1;
    vt[3].init[320*2 +: 320] = '1;
    vt[3].exp[320*2 +: 320]  = '1;
    vt[4].op = 1'b0;
    vt[4].init[64*(5*3+2) +: 64] = 64'h8000000000000000;
    vt[4].exp[64*(5*3+2) +: 64]  = 64'h8000000000000000;
    for (int y = 0; y < 5; y++) begin
      vt[4].exp[64*(5*y+1) +: 64] = 64'd1;
      vt[4].exp[64*(5*y+3) +: 64] = 64'h8000000000000000;
    end
    vt[5].op = 1'b1;
    vt[5].init[320*4 +: 320] = {64'd16, 64'd8, 64'd4, 64'd2, 64'd1};
    vt[5].exp[320*4 +: 320]  = {64'd18, 64'd9, 64'd20, 64'd10, 64'd5};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check_state("reset", '0);
    chk("reset_flags", {317'h0, busy, done, err}, '0);

    for (int i = 0; i < 6; i++) begin
      load_state(vt[i].init);
      run_step(vt[i].op, vt[i].rc, lat);
      chk($sformatf("v%0d_latency", i), 320'(lat), vt[i].op ? 320'd6 : 320'd12);
      check_state($sformatf("v%0d", i), vt[i].exp);
      chk($sformatf("v%0d_idle", i), {318'h0, busy, done}, '0);
    end

    // Write during theta: ignored, single err pulse, result intact
    load_state(vt[1].init);
    start = 1'b1; op = 1'b0; rc = '0;
    tick();
    start = 1'b0;
    tick();
    plane_we = 1'b1; plane_idx = 3'd0; plane_wdata = '1;
    tick();
    plane_we = 1'b0;
    chk("midwr_err_pulse", 320'(err), 320'd1);
    tick();
    chk("midwr_err_clear", 320'(err), 320'd0);
    wait_done(lat);
    chk("midwr_done_seen", 320'(lat > 0), 320'd1);
    tick();
    check_state("midwr", vt[1].exp);

    // Out-of-range index in IDLE
    plane_we = 1'b1; plane_idx = 3'd5; plane_wdata = '1;
    #1;
    chk("idx5_rdata", plane_rdata, '0);
    tick();
    plane_we = 1'b0;
    chk("idx5_err_pulse", 320'(err), 320'd1);
    tick();
    chk("idx5_err_clear", 320'(err), 320'd0);
    check_state("idx5", vt[1].exp);

    // Write and start in the same IDLE cycle; start held high for the whole step
    load_state('0);
    plane_we = 1'b1; plane_idx = 3'd0; plane_wdata = {64'd0, 64'd0, 64'd1, 64'd0, 64'd0};
    start = 1'b1; op = 1'b1; rc = '0;
    tick();
    plane_we = 1'b0;
    dcnt = 0; ecnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        dcnt++;
        start = 1'b0;
      end
      if (err) ecnt++;
      tick();
    end
    start = 1'b0;
    chk("hold_done_count", 320'(dcnt), 320'd1);
    chk("hold_no_err", 320'(ecnt), 320'd0);
    chk("hold_idle", 320'(busy), 320'd0);
    s = '0;
    s[0 +: 320] = {64'd0, 64'd0, 64'd1, 64'd0, 64'd1};
    check_state("hold", s);

    // Reset three cycles into theta: state cleared, no done
    load_state(vt[4].init);
    start = 1'b1; op = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) dcnt++;
      tick();
    end
    chk("rstmid_no_done", 320'(dcnt), 320'd0);
    chk("rstmid_idle", 320'(busy), 320'd0);
    check_state("rstmid", '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
